// File: rtl/mult_fixed_complex_pipe_if.sv
// Operand/result bundle for the pipelined complex multiplier: valid/ready on both sides
// plus overflow reporting. The source/sink side takes master, the multiplier takes slave.
interface mult_fixed_complex_pipe_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a_Re;
  logic [W-1:0] a_Im;
  logic [W-1:0] b_Re;
  logic [W-1:0] b_Im;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] y_Re;
  logic [W-1:0] y_Im;
  logic         ovf_re;
  logic         ovf_im;
  logic         ovf_sticky;
  logic         ovf_clr;

  modport master (
    output in_valid, a_Re, a_Im, b_Re, b_Im, out_ready, ovf_clr,
    input  in_ready, out_valid, y_Re, y_Im, ovf_re, ovf_im, ovf_sticky
  );

  modport slave (
    input  in_valid, a_Re, a_Im, b_Re, b_Im, out_ready, ovf_clr,
    output in_ready, out_valid, y_Re, y_Im, ovf_re, ovf_im, ovf_sticky
  );
endinterface

// File: rtl/mult_fixed_complex_pipe.sv
// 3-stage signed fixed-point complex multiplier y = a*b with valid/ready flow control,
// optional round-half-up rescale, saturate-or-wrap output and overflow flags.
module mult_fixed_complex_pipe #(
  parameter int QI       = 4,
  parameter int QF       = 4,
  parameter int ROUND    = 1,
  parameter int SATURATE = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  mult_fixed_complex_pipe_if.slave    bus
);
  localparam int W  = QI + QF;
  localparam int P  = 2 * W;      // partial product width
  localparam int X  = 2 * W + 1;  // sum/difference width
  localparam int TW = 2 * W + 2;  // rescale width, headroom for the rounding add

  typedef logic signed [TW-1:0] wide_t;
  typedef struct packed {
    logic         ovf;
    logic [W-1:0] y;
  } rescale_t;

  localparam wide_t RND  = (ROUND != 0) ? (wide_t'(1) <<< (QF - 1)) : wide_t'(0);
  localparam wide_t MAXV = wide_t'({(W-1){1'b1}});
  localparam wide_t MINV = ~MAXV;

  function automatic rescale_t rescale(input logic signed [X-1:0] x);
    wide_t    t;
    rescale_t r;
    t     = (wide_t'(x) + RND) >>> QF;
    r.ovf = (t > MAXV) || (t < MINV);
    if ((SATURATE != 0) && (t > MAXV))      r.y = MAXV[W-1:0];
    else if ((SATURATE != 0) && (t < MINV)) r.y = MINV[W-1:0];
    else                                    r.y = t[W-1:0];
    return r;
  endfunction

  logic                w_adv;
  logic                r_s1_valid;
  logic                r_s2_valid;
  logic                r_s3_valid;
  logic signed [P-1:0] r_ac;
  logic signed [P-1:0] r_bd;
  logic signed [P-1:0] r_ad;
  logic signed [P-1:0] r_bc;
  logic signed [X-1:0] r_re;
  logic signed [X-1:0] r_im;
  logic [W-1:0]        r_y_re;
  logic [W-1:0]        r_y_im;
  logic                r_ovf_re;
  logic                r_ovf_im;
  logic                r_ovf_sticky;
  rescale_t            w_re_res;
  rescale_t            w_im_res;

  // The whole pipe moves as one: a full output stage that is not taken freezes every stage.
  assign w_adv        = ~r_s3_valid | bus.out_ready;
  assign w_re_res     = rescale(r_re);
  assign w_im_res     = rescale(r_im);

  assign bus.in_ready   = w_adv;
  assign bus.out_valid  = r_s3_valid;
  assign bus.y_Re       = r_y_re;
  assign bus.y_Im       = r_y_im;
  assign bus.ovf_re     = r_ovf_re;
  assign bus.ovf_im     = r_ovf_im;
  assign bus.ovf_sticky = r_ovf_sticky;

  // NOTE: stage-1/2 data registers carry no reset; their valid bits qualify them, so clearing
  // the valids is enough to discard in-flight samples and the wide products stay reset-free.
  always_ff @(posedge clk) begin
    if (w_adv && bus.in_valid) begin
      r_ac <= P'($signed(bus.a_Re)) * P'($signed(bus.b_Re));
      r_bd <= P'($signed(bus.a_Im)) * P'($signed(bus.b_Im));
      r_ad <= P'($signed(bus.a_Re)) * P'($signed(bus.b_Im));
      r_bc <= P'($signed(bus.a_Im)) * P'($signed(bus.b_Re));
    end
    if (w_adv && r_s1_valid) begin
      r_re <= X'(r_ac) - X'(r_bd);
      r_im <= X'(r_ad) + X'(r_bc);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s2_valid   <= 1'b0;
      r_s3_valid   <= 1'b0;
      r_y_re       <= '0;
      r_y_im       <= '0;
      r_ovf_re     <= 1'b0;
      r_ovf_im     <= 1'b0;
      r_ovf_sticky <= 1'b0;
    end else begin
      if (w_adv) begin
        r_s1_valid <= bus.in_valid;
        r_s2_valid <= r_s1_valid;
        r_s3_valid <= r_s2_valid;
        if (r_s2_valid) begin
          r_y_re   <= w_re_res.y;
          r_y_im   <= w_im_res.y;
          r_ovf_re <= w_re_res.ovf;
          r_ovf_im <= w_im_res.ovf;
        end
      end
      // Clear beats a set landing on the same edge.
      if (bus.ovf_clr)
        r_ovf_sticky <= 1'b0;
      else if (w_adv && r_s2_valid && (w_re_res.ovf || w_im_res.ovf))
        r_ovf_sticky <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mult_fixed_complex_pipe.sv
// Bench for mult_fixed_complex_pipe: one round/saturate instance and one truncate/wrap instance
// share stimulus; results are scored against a real-valued model of the complex product.
module tb_mult_fixed_complex_pipe;
  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  int   run      = 0;
  int   max_run  = 0;
  bit   rnd_ready = 1'b0;

  typedef struct {
    logic [7:0] yre, yim, yre2, yim2;
    logic       ore, oim, ore2, oim2;
  } exp_t;
  exp_t sb[$];

  mult_fixed_complex_pipe_if #(.W(8)) bif ();
  mult_fixed_complex_pipe_if #(.W(8)) bif2 ();

  assign bif2.in_valid  = bif.in_valid;
  assign bif2.a_Re      = bif.a_Re;
  assign bif2.a_Im      = bif.a_Im;
  assign bif2.b_Re      = bif.b_Re;
  assign bif2.b_Im      = bif.b_Im;
  assign bif2.out_ready = bif.out_ready;
  assign bif2.ovf_clr   = bif.ovf_clr;

  mult_fixed_complex_pipe #(.QI(4), .QF(4), .ROUND(1), .SATURATE(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bif)
  );
  mult_fixed_complex_pipe #(.QI(4), .QF(4), .ROUND(0), .SATURATE(0)) dut_tw (
    .clk(clk), .rst_n(rst_n), .bus(bif2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Real-valued reference: product value, scaled to output LSBs, then floor (optionally +0.5).
  function automatic void rescale_ref(input int raw, input bit rnd, input bit sat,
                                      output logic [7:0] y, output logic ovf);
    real v;
    int  t;
    v   = raw / 256.0;
    t   = int'($floor(v * 16.0 + (rnd ? 0.5 : 0.0)));
    ovf = (t > 127) || (t < -128);
    if (sat && t > 127)       y = 8'h7F;
    else if (sat && t < -128) y = 8'h80;
    else                      y = t[7:0];
  endfunction

  function automatic exp_t model(input logic [7:0] ar, ai, br, bi);
    int   sar, sai, sbr, sbi, re, im;
    exp_t e;
    sar = $signed(ar); sai = $signed(ai); sbr = $signed(br); sbi = $signed(bi);
    re  = sar * sbr - sai * sbi;
    im  = sar * sbi + sai * sbr;
    rescale_ref(re, 1'b1, 1'b1, e.yre,  e.ore);
    rescale_ref(im, 1'b1, 1'b1, e.yim,  e.oim);
    rescale_ref(re, 1'b0, 1'b0, e.yre2, e.ore2);
    rescale_ref(im, 1'b0, 1'b0, e.yim2, e.oim2);
    return e;
  endfunction

  // Scoreboard and throughput monitor, sampled on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bif.out_valid && bif.out_ready) run++;
    else run = 0;
    if (run > max_run) max_run = run;
    if (rst_n) check("tw_valid_match", bif2.out_valid, bif.out_valid);
    if (rst_n && bif.out_valid && bif.out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_out", bif.out_valid, 1'b0);
      end else begin
        e = sb.pop_front();
        check("sb_y_re",     bif.y_Re,    e.yre);
        check("sb_y_im",     bif.y_Im,    e.yim);
        check("sb_ovf_re",   bif.ovf_re,  e.ore);
        check("sb_ovf_im",   bif.ovf_im,  e.oim);
        check("sb_tw_y_re",  bif2.y_Re,   e.yre2);
        check("sb_tw_y_im",  bif2.y_Im,   e.yim2);
        check("sb_tw_ovf_re", bif2.ovf_re, e.ore2);
        check("sb_tw_ovf_im", bif2.ovf_im, e.oim2);
        if (e.ore || e.oim) check("sb_sticky", bif.ovf_sticky, 1'b1);
      end
    end
  end

  // Present one sample and hold it until accepted; returns at posedge+1.
  task automatic send(input logic [7:0] ar, ai, br, bi);
    bit acc = 1'b0;
    bif.a_Re = ar; bif.a_Im = ai; bif.b_Re = br; bif.b_Im = bi;
    bif.in_valid = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      if (rnd_ready) bif.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = bif.in_ready;
      if (acc) acc_cyc = cyc;
      @(posedge clk); #1;
    end
    if (acc) sb.push_back(model(ar, ai, br, bi));
    else check("send_timeout", bif.in_ready, 1'b1);
  endtask

  task automatic idle();
    bif.in_valid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [7:0] yre, yim, input logic ore, oim,
                            input logic [7:0] yre2, yim2);
    bit found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      found = bif.out_valid;
    end
    if (found) begin
      check({tag, "_y_re"},    bif.y_Re,   yre);
      check({tag, "_y_im"},    bif.y_Im,   yim);
      check({tag, "_ovf_re"},  bif.ovf_re, ore);
      check({tag, "_ovf_im"},  bif.ovf_im, oim);
      check({tag, "_tw_y_re"}, bif2.y_Re,  yre2);
      check({tag, "_tw_y_im"}, bif2.y_Im,  yim2);
      check({tag, "_latency"}, cyc - acc_cyc, 3);
    end else begin
      check({tag, "_timeout"}, bif.out_valid, 1'b1);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) begin
      @(posedge clk); #1;
    end
    check("drain", sb.size(), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    bif.in_valid = 1'b0; bif.out_ready = 1'b1; bif.ovf_clr = 1'b0;
    bif.a_Re = '0; bif.a_Im = '0; bif.b_Re = '0; bif.b_Im = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bif.out_valid, 1'b0);
    check("rst_y_re",      bif.y_Re, 8'h00);
    check("rst_y_im",      bif.y_Im, 8'h00);
    check("rst_ovf",       {bif.ovf_re, bif.ovf_im, bif.ovf_sticky}, 3'b000);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", bif.in_ready, 1'b1);
    @(posedge clk); #1;

    // Mixed result: real fits, imaginary overflows.
    send(8'h34, 8'h20, 8'h21, 8'h30); idle();
    expect_out("t1", 8'h0B, 8'h7F, 1'b0, 1'b1, 8'h0B, 8'hDE);
    check("t1_sticky", bif.ovf_sticky, 1'b1);
    bif.ovf_clr = 1'b1;
    @(posedge clk); #1;
    bif.ovf_clr = 1'b0;
    check("clr_sticky",    bif.ovf_sticky,  1'b0);
    check("clr_tw_sticky", bif2.ovf_sticky, 1'b0);

    // (1+i)(1-i) = 2, single then eight back-to-back.
    send(8'h10, 8'h10, 8'h10, 8'hF0); idle();
    expect_out("t2", 8'h20, 8'h00, 1'b0, 1'b0, 8'h20, 8'h00);
    max_run = 0;
    for (int i = 0; i < 8; i++) send(8'h10, 8'h10, 8'h10, 8'hF0);
    idle();
    drain();
    check("t2_stream_run", max_run, 8);
    check("t2_no_sticky", bif.ovf_sticky, 1'b0);

    // Half-LSB rounding, positive and negative.
    send(8'h01, 8'h00, 8'h08, 8'h00); idle();
    expect_out("t3p", 8'h01, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
    send(8'hFF, 8'h00, 8'h08, 8'h00); idle();
    expect_out("t3n", 8'h00, 8'h00, 1'b0, 1'b0, 8'hFF, 8'h00);

    // Most-negative squared.
    send(8'h80, 8'h00, 8'h80, 8'h00); idle();
    expect_out("t4", 8'h7F, 8'h00, 1'b1, 1'b0, 8'h00, 8'h00);
    check("t4_tw_ovf_re", bif2.ovf_re, 1'b1);

    // Backpressure: three fill the pipe, the fourth waits.
    bif.out_ready = 1'b0;
    send(8'h34, 8'h20, 8'h21, 8'h30);
    send(8'h10, 8'h10, 8'h10, 8'hF0);
    send(8'h01, 8'h00, 8'h08, 8'h00);
    bif.a_Re = 8'h80; bif.a_Im = 8'h00; bif.b_Re = 8'h80; bif.b_Im = 8'h00;
    bif.in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("t5_in_ready",  bif.in_ready,  1'b0);
      check("t5_out_valid", bif.out_valid, 1'b1);
      check("t5_hold_y_re", bif.y_Re, sb[0].yre);
      check("t5_hold_y_im", bif.y_Im, sb[0].yim);
      @(posedge clk); #1;
    end
    bif.out_ready = 1'b1;
    send(8'h80, 8'h00, 8'h80, 8'h00); idle();
    drain();

    // Reset with three samples in flight.
    send(8'h21, 8'h13, 8'h7A, 8'h85);
    send(8'h34, 8'h20, 8'h21, 8'h30);
    send(8'h80, 8'h00, 8'h80, 8'h00);
    idle();
    rst_n = 1'b0;
    @(posedge clk); #1;
    sb.delete();
    check("t6_out_valid", bif.out_valid,  1'b0);
    check("t6_in_ready",  bif.in_ready,   1'b1);
    check("t6_sticky",    bif.ovf_sticky, 1'b0);
    check("t6_y_re",      bif.y_Re,       8'h00);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    check("t6_no_stale", bif.out_valid, 1'b0);

    // Random operands with random downstream stalls.
    rnd_ready = 1'b1;
    for (int i = 0; i < 80; i++)
      send(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
           8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    idle();
    rnd_ready = 1'b0;
    bif.out_ready = 1'b1;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
